comb_mux_8to1: RTL and testbench
================================

Name: comb_mux_8to1

Overview:
- Eight-input, WIDTH-bit (default 4) one-hot-free multiplexer; 3-bit sel picks one of in0..in7.
- Primary output `out` is purely combinational, zero latency.
- A registered copy `out_q` is provided for timing-critical consumers downstream.
- Used wherever a datapath picks one of eight nibble sources (operand/result select).

Parameters:
- WIDTH, 4, bit width of each data input and of every data output.

Ports:
- clk, input, 1, rising-edge clock for the registered output only.
- reset, input, 1, asynchronous active-high reset; clears registered state only.
- in0, input, WIDTH, data input selected when sel=0.
- in1, input, WIDTH, data input selected when sel=1.
- in2, input, WIDTH, data input selected when sel=2.
- in3, input, WIDTH, data input selected when sel=3.
- in4, input, WIDTH, data input selected when sel=4.
- in5, input, WIDTH, data input selected when sel=5.
- in6, input, WIDTH, data input selected when sel=6.
- in7, input, WIDTH, data input selected when sel=7.
- sel, input, 3, select index 0..7.
- out, output, WIDTH, combinational selected data.
- out_q, output, WIDTH, out registered one cycle.

Behaviour:
- out = in[sel] at all times, same delta/cycle, no clock or reset dependence.
  - Combinational, no latches.
  - All 8 sel codes are legal; no default/X case is reachable.
  - If sel is X/Z, out is X in simulation.
- Values pass through unmodified: no sign extension, truncation or arithmetic. Non-selected inputs have no effect on out.
- out_q:
  - Captures out on every rising clk edge.
  - One-cycle latency.
  - No enable.
- Reset:
  - Asserting reset forces out_q to 0 immediately, independent of clk.
  - out_q stays 0 while reset is high.
  - out is unaffected by reset, including during reset and mid-operation.
- After reset deasserts, the first rising edge loads the current out into out_q.
- Input change and clock edge at the same time: out_q takes the value of out settled before the edge.

Optional Feature:
- Macro: COMB_MUX_8TO1_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit) = XOR-reduction of out (even parity), combinational.
  - Adds out_par_q, registered like out_q, reset to 0.
- When undefined: neither port exists; behaviour of out/out_q is identical in both builds.

Decomposition:
- Shared package comb_mux_pkg:
  - localparam NUM_IN = 8.
  - localparam SEL_W = 3.
  - Typedef sel_t = logic [SEL_W-1:0].
- One natural sub-module, mux2_w: WIDTH-bit 2:1 mux.
  - Instantiated as a 3-level tree (4+2+1), level k controlled by sel[k].
  - A flat case-statement implementation is equally acceptable; results must match.
- Output register is inline in the top block.

Test Plan (each vector applied, outputs checked 8 time units later):
- Zero and pass-through on sel=0:
  - All inputs 0, sel=0 -> out=0.
  - Then in0 = 1..8 with others 0 -> out tracks in0 (1..8).
- Ignore non-selected inputs:
  - in1..in7 = 1, sel=0, in0 swept 0..8 -> out = in0 each time.
- Each select code:
  - sel=k for k = 1..7 with only in_k = 1 -> out=1.
  - Same sel with all inputs 0 -> out=0.
- Random:
  - 20 vectors of random 4-bit inputs and 3-bit sel -> out == in[sel].
  - out_q equals the previous cycle's out.
- Reset:
  - Assert reset asynchronously with out=0xA -> out_q=0 at once, out stays 0xA.
  - Deassert reset -> out_q=0xA after the next rising edge.
- Parity build (COMB_MUX_8TO1_PARITY_EN):
  - sel=3, in3=0x7 -> out_par=1.
  - in3=0xF -> out_par=0.

Source files
------------

// File: rtl/comb_mux_8to1_pkg.sv
//============================================================================
// Module      : comb_mux_pkg
// Description : Shared constants and types for the 8:1 multiplexer slice.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package comb_mux_pkg;

  localparam int NUM_IN = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : comb_mux_pkg

`default_nettype wire

// File: rtl/comb_mux_8to1_if.sv
//============================================================================
// Module      : comb_mux_8to1_if
// Description : Data/select bundle for the 8:1 multiplexer. The parity
//               signals exist only when COMB_MUX_8TO1_PARITY_EN is defined.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface comb_mux_8to1_if
  import comb_mux_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] in4;
  logic [WIDTH-1:0] in5;
  logic [WIDTH-1:0] in6;
  logic [WIDTH-1:0] in7;
  sel_t             sel;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
`ifdef COMB_MUX_8TO1_PARITY_EN
  logic             out_par;
  logic             out_par_q;
`endif

  // Source side: drives data and select, observes the results
  modport master (
    output in0, in1, in2, in3, in4, in5, in6, in7, sel,
`ifdef COMB_MUX_8TO1_PARITY_EN
    input  out_par, out_par_q,
`endif
    input  out, out_q
  );

  // Multiplexer side
  modport slave (
    input  in0, in1, in2, in3, in4, in5, in6, in7, sel,
`ifdef COMB_MUX_8TO1_PARITY_EN
    output out_par, out_par_q,
`endif
    output out, out_q
  );

endinterface : comb_mux_8to1_if

`default_nettype wire

// File: rtl/comb_mux_8to1_mux2_w.sv
//============================================================================
// Module      : mux2_w
// Description : WIDTH-bit 2:1 multiplexer, one node of the select tree.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mux2_w #(
  parameter int WIDTH = 4
) (
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  input  wire logic             i_s,
  output      logic [WIDTH-1:0] o_y
);

  // Select i_b when i_s is high; an unknown select propagates as X
  assign o_y = i_s ? i_b : i_a;

endmodule : mux2_w

`default_nettype wire

// File: rtl/comb_mux_8to1.sv
//============================================================================
// Module      : comb_mux_8to1
// Description : 8:1 WIDTH-bit multiplexer with a combinational output and a
//               one-cycle registered copy. Built as a 3-level 2:1 tree where
//               level k is steered by sel[k].
//               Optional macro COMB_MUX_8TO1_PARITY_EN adds even parity of
//               the selected data (combinational and registered).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module comb_mux_8to1 #(
  parameter int WIDTH = 4
) (
  input wire logic        clk,
  input wire logic        reset,
  comb_mux_8to1_if.slave  bus
);

  import comb_mux_pkg::*;

  localparam int C_L0_N = NUM_IN / 2;
  localparam int C_L1_N = NUM_IN / 4;

  logic [WIDTH-1:0] w_in [NUM_IN];
  logic [WIDTH-1:0] w_l0 [C_L0_N];
  logic [WIDTH-1:0] w_l1 [C_L1_N];
  logic [WIDTH-1:0] w_out;
  sel_t             w_sel;
  logic [WIDTH-1:0] r_out_q;

  assign w_sel   = bus.sel;
  assign w_in[0] = bus.in0;
  assign w_in[1] = bus.in1;
  assign w_in[2] = bus.in2;
  assign w_in[3] = bus.in3;
  assign w_in[4] = bus.in4;
  assign w_in[5] = bus.in5;
  assign w_in[6] = bus.in6;
  assign w_in[7] = bus.in7;

  // Level 0: adjacent pairs, steered by the select LSB
  for (genvar g = 0; g < C_L0_N; g++) begin : g_lvl0
    mux2_w #(.WIDTH(WIDTH)) u_mux (
      .i_a (w_in[2*g]),
      .i_b (w_in[2*g+1]),
      .i_s (w_sel[0]),
      .o_y (w_l0[g])
    );
  end

  // Level 1: pairs of level-0 results, steered by sel[1]
  for (genvar g = 0; g < C_L1_N; g++) begin : g_lvl1
    mux2_w #(.WIDTH(WIDTH)) u_mux (
      .i_a (w_l0[2*g]),
      .i_b (w_l0[2*g+1]),
      .i_s (w_sel[1]),
      .o_y (w_l1[g])
    );
  end

  // Level 2: final choice between lower and upper halves, steered by sel[2]
  mux2_w #(.WIDTH(WIDTH)) u_mux_root (
    .i_a (w_l1[0]),
    .i_b (w_l1[1]),
    .i_s (w_sel[2]),
    .o_y (w_out)
  );

  assign bus.out = w_out;

  // Registered copy of the selected data; reset clears it without a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_q <= '0;
    end else begin
      r_out_q <= w_out;
    end
  end

  assign bus.out_q = r_out_q;

`ifdef COMB_MUX_8TO1_PARITY_EN
  logic w_par;
  logic r_par_q;

  assign w_par       = ^w_out;
  assign bus.out_par = w_par;

  // Registered parity, aligned with out_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par_q <= 1'b0;
    end else begin
      r_par_q <= w_par;
    end
  end

  assign bus.out_par_q = r_par_q;
`endif

endmodule : comb_mux_8to1

`default_nettype wire

// File: tb/tb_comb_mux_8to1.sv
//============================================================================
// Module      : tb_comb_mux_8to1
// Description : Directed self-checking bench for comb_mux_8to1.
//               Parity checks are included when COMB_MUX_8TO1_PARITY_EN is set.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_comb_mux_8to1;

  localparam int C_W = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  comb_mux_8to1_if #(.WIDTH(C_W)) u_if ();

  comb_mux_8to1 #(.WIDTH(C_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Nibble k of vec drives in_k
  task automatic drive(input logic [8*C_W-1:0] vec, input logic [2:0] s);
    u_if.in0 = vec[0*C_W +: C_W];
    u_if.in1 = vec[1*C_W +: C_W];
    u_if.in2 = vec[2*C_W +: C_W];
    u_if.in3 = vec[3*C_W +: C_W];
    u_if.in4 = vec[4*C_W +: C_W];
    u_if.in5 = vec[5*C_W +: C_W];
    u_if.in6 = vec[6*C_W +: C_W];
    u_if.in7 = vec[7*C_W +: C_W];
    u_if.sel = s;
  endtask

  // Apply one vector just after a rising edge, check out 8 time units later
  task automatic apply_chk(input string tag, input logic [8*C_W-1:0] vec,
                           input logic [2:0] s, input logic [C_W-1:0] exp);
    @(posedge clk);
    #1;
    drive(vec, s);
    #8;
    check_eq(tag, 32'(u_if.out), 32'(exp));
  endtask

  initial begin
    logic [8*C_W-1:0] vec;
    logic [2:0]       s;
    logic [C_W-1:0]   exp;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive('0, 3'd0);

    #2;
    check_eq("reset_out_q", 32'(u_if.out_q), 32'h0);
    #10;
    reset = 1'b0;

    // Zero, then in0 pass-through
    apply_chk("zero_sel0", '0, 3'd0, 4'h0);
    for (int v = 1; v <= 8; v++) begin
      vec = '0;
      vec[3:0] = 4'(v);
      apply_chk("pass_in0", vec, 3'd0, 4'(v));
    end

    // Non-selected inputs held at 1 must not leak through
    for (int v = 0; v <= 8; v++) begin
      vec = {7{4'h1}} << C_W;
      vec[3:0] = 4'(v);
      apply_chk("ignore_others", vec, 3'd0, 4'(v));
    end

    // Each select code with only its input set, then with all inputs 0
    for (int k = 1; k < 8; k++) begin
      vec = '0;
      vec[k*C_W +: C_W] = 4'h1;
      apply_chk("sel_one", vec, 3'(k), 4'h1);
      apply_chk("sel_zero", '0, 3'(k), 4'h0);
    end

    // Random vectors; out_q checked one edge later against the same value
    for (int i = 0; i < 20; i++) begin
      vec = $urandom;
      s   = 3'($urandom_range(0, 7));
      exp = vec[s*C_W +: C_W];
      apply_chk("rand_out", vec, s, exp);
      @(posedge clk);
      #1;
      check_eq("rand_out_q", 32'(u_if.out_q), 32'(exp));
    end

    // Asynchronous reset with out = 0xA
    vec = '0;
    vec[2*C_W +: C_W] = 4'hA;
    apply_chk("pre_reset_out", vec, 3'd2, 4'hA);
    @(posedge clk);
    #1;
    check_eq("pre_reset_out_q", 32'(u_if.out_q), 32'hA);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset_out_q", 32'(u_if.out_q), 32'h0);
    check_eq("reset_out_kept", 32'(u_if.out), 32'hA);
    @(posedge clk);
    #1;
    check_eq("reset_hold_out_q", 32'(u_if.out_q), 32'h0);
    check_eq("reset_hold_out", 32'(u_if.out), 32'hA);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_reset_still0", 32'(u_if.out_q), 32'h0);
    @(posedge clk);
    #1;
    check_eq("post_reset_load", 32'(u_if.out_q), 32'hA);

`ifdef COMB_MUX_8TO1_PARITY_EN
    vec = '0;
    vec[3*C_W +: C_W] = 4'h7;
    apply_chk("par_out_7", vec, 3'd3, 4'h7);
    check_eq("par_7", 32'(u_if.out_par), 32'h1);
    @(posedge clk);
    #1;
    check_eq("par_q_7", 32'(u_if.out_par_q), 32'h1);
    vec[3*C_W +: C_W] = 4'hF;
    apply_chk("par_out_F", vec, 3'd3, 4'hF);
    check_eq("par_F", 32'(u_if.out_par), 32'h0);
    @(posedge clk);
    #1;
    check_eq("par_q_F", 32'(u_if.out_par_q), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_comb_mux_8to1

`default_nettype wire
